vga_timing_gen: RTL and testbench

//  640x480@60 Hz VGA timing generator. Divides the 100 MHz system clock to a 25 MHz pixel enable and runs
//  the horizontal/vertical counters. Drives h_cnt/v_cnt into the scene renderers, which derive frame-buffer

---
 rtl/vga_pkg.sv | 15 +
 rtl/pixel_en_div.sv | 31 +++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by the timing generator and scene blocks.
package vga_pkg;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;
endpackage

// File: rtl/pixel_en_div.sv
// Divides the system clock into a registered one-clk pixel enable, period CLK_DIV (CLK_DIV >= 2).
module pixel_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pclk_en
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pclk_en_q, pclk_en_d;

  always_comb begin
    pclk_en_d = (div_q == DIV_MAX);
    div_d     = pclk_en_d ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      pclk_en_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pclk_en_q <= pclk_en_d;
    end
  end

  assign pclk_en = pclk_en_q;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, h/v counters and registered sync/valid decode.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/valid by one pixel (frame-buffer ROM read latency).
module vga_timing_gen
  import vga_pkg::coord_t;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pclk_en,
  output coord_t h_cnt,
  output coord_t v_cnt,
  output logic   hsync,
  output logic   vsync,
  output logic   valid,
  output logic   line_start,
  output logic   frame_start
);
  localparam int     HT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int     VT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_VEND = coord_t'(H_VIS);
  localparam coord_t V_VEND = coord_t'(V_VIS);
  localparam coord_t HS_LO  = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_VIS + V_FP + V_SYNC);

  coord_t h_q, h_d, v_q, v_d;
  logic   hs_q, hs_d, vs_q, vs_d, vld_q, vld_d;
  logic   line_q, line_d, frame_q, frame_d;

  pixel_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .pclk_en (pclk_en)
  );

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (pclk_en) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    // Decode from the next counter values so the registered flags line up with h_cnt/v_cnt.
    hs_d  = !((h_d >= HS_LO) && (h_d < HS_HI));
    vs_d  = !((v_d >= VS_LO) && (v_d < VS_HI));
    vld_d = (h_d < H_VEND) && (v_d < V_VEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      vld_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vld_q   <= vld_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d, vld_dly_q, vld_dly_d;

  // Captures the flags of the pixel being left, so outputs trail the counters by one pixel.
  always_comb begin
    hs_dly_d  = hs_dly_q;
    vs_dly_d  = vs_dly_q;
    vld_dly_d = vld_dly_q;
    if (pclk_en) begin
      hs_dly_d  = hs_q;
      vs_dly_d  = vs_q;
      vld_dly_d = vld_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_dly_q  <= 1'b1;
      vs_dly_q  <= 1'b1;
      vld_dly_q <= 1'b0;
    end else begin
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      vld_dly_q <= vld_dly_d;
    end
  end

  assign hsync = hs_dly_q;
  assign vsync = vs_dly_q;
  assign valid = vld_dly_q;
`else
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign valid = vld_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen; full horizontal timing, shortened vertical timing to keep frames short.
module tb_vga_timing_gen;
  localparam int CD = 4;
  localparam int HV = vga_pkg::H_VIS;
  localparam int HF = vga_pkg::H_FP;
  localparam int HS = vga_pkg::H_SYNC;
  localparam int HB = vga_pkg::H_BP;
  localparam int VV = 8;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
`ifdef VGA_SYNC_DELAY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  typedef struct packed {
    logic       pclk_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       line_start;
    logic       frame_start;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic pclk_en, hsync, vsync, valid, line_start, frame_start;
  logic [9:0] h_cnt, v_cnt;
  obs_t got;
  int errors = 0;
  int checks = 0;
  int e = 0;  // clk edges since reset release

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pclk_en(pclk_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .line_start(line_start), .frame_start(frame_start)
  );

  assign got = {pclk_en, h_cnt, v_cnt, hsync, vsync, valid, line_start, frame_start};

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) if (rst) e <= 0; else e <= e + 1;

  // Expected outputs after ec edges: pixel n = (ec-1)/CD, raster position = n mod frame.
  function automatic obs_t model(int ec);
    obs_t x;
    int n, p, ph, pv;
    x = '0;
    x.hsync = 1'b1;
    x.vsync = 1'b1;
    if (ec == 0) return x;
    x.pclk_en = (ec % CD == 0);
    n = (ec - 1) / CD;
    x.h = 10'(n % HT);
    x.v = 10'((n / HT) % VT);
    x.line_start  = (ec > 1) && ((ec - 1) % CD == 0) && (n % HT == 0);
    x.frame_start = x.line_start && ((n / HT) % VT == 0);
    p = n - LAG;
    if (p >= 0) begin
      ph = p % HT;
      pv = (p / HT) % VT;
      x.hsync = !(ph >= HV + HF && ph < HV + HF + HS);
      x.vsync = !(pv >= VV + VF && pv < VV + VF + VS);
      x.valid = (ph < HV) && (pv < VV);
    end
    return x;
  endfunction

  task automatic test_reset();
    int first = -1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got !== model(0)) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, model(0)); end
    rst = 1'b0;
    for (int i = 0; i < 2 * CD + 2; i++) begin
      @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL reset_release e=%0d got=%h exp=%h", e, got, model(e));
      end
      if (pclk_en && first < 0) first = e;
    end
    checks++;
    if (first != CD) begin errors++; $display("FAIL first_pclk_en got=%0d exp=%0d", first, CD); end
  endtask

  task automatic test_divider();
    int pulses = 0, h0, skip;
    logic prev = 1'b0;
    skip = $urandom_range(0, CD - 1);
    repeat (skip) @(negedge clk);
    h0 = int'(h_cnt);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL divider e=%0d got=%h exp=%h", e, got, model(e));
      end
      if (pclk_en) pulses++;
      checks++;
      if (prev && pclk_en) begin errors++; $display("FAIL pclk_width e=%0d got=2 exp=1", e); end
      prev = pclk_en;
    end
    checks++;
    if (pulses != 10) begin errors++; $display("FAIL pclk_count got=%0d exp=10", pulses); end
    checks++;
    if (int'(h_cnt) - h0 != 10) begin errors++; $display("FAIL h_advance got=%0d exp=10", int'(h_cnt) - h0); end
  endtask

  task automatic test_line_wrap();
    int target;
    target = (5 * HT + HT - 1) * CD + 1;
    for (int k = 0; k < 30000 && e < target; k++) begin
      @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL line_run e=%0d got=%h exp=%h", e, got, model(e));
      end
    end
    checks++;
    if (got.h !== 10'(HT - 1) || got.v !== 10'd5) begin
      errors++; $display("FAIL pre_wrap got=(%0d,%0d) exp=(%0d,5)", got.h, got.v, HT - 1);
    end
    repeat (CD) @(negedge clk);
    checks++;
    if (got.h !== 10'd0 || got.v !== 10'd6 || got.line_start !== 1'b1 || got.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL line_wrap got=(%0d,%0d) ls=%b fs=%b exp=(0,6) ls=1 fs=0",
               got.h, got.v, got.line_start, got.frame_start);
    end
    @(negedge clk);
    checks++;
    if (line_start !== 1'b0) begin errors++; $display("FAIL line_start_width got=%b exp=0", line_start); end
  endtask

  task automatic test_hsync_line();
    int hs_clks = 0, vld_clks = 0, hmin = 9999, hmax = -1, k = 0;
    while (line_start !== 1'b1 && k < HT * CD + CD) begin @(negedge clk); k++; end
    checks++;
    if (line_start !== 1'b1) begin errors++; $display("FAIL line_start_timeout got=0 exp=1"); end
    for (int i = 0; i < HT * CD; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL line_scan e=%0d got=%h exp=%h", e, got, model(e));
      end
      if (!hsync) begin
        hs_clks++;
        if (int'(h_cnt) < hmin) hmin = int'(h_cnt);
        if (int'(h_cnt) > hmax) hmax = int'(h_cnt);
      end
      if (valid) vld_clks++;
    end
    checks++;
    if (hs_clks != HS * CD) begin errors++; $display("FAIL hsync_width got=%0d exp=%0d", hs_clks, HS * CD); end
    checks++;
    if (hmin != HV + HF + LAG || hmax != HV + HF + HS - 1 + LAG) begin
      errors++; $display("FAIL hsync_span got=%0d..%0d exp=%0d..%0d", hmin, hmax, HV + HF + LAG, HV + HF + HS - 1 + LAG);
    end
    checks++;
    if (vld_clks != HV * CD) begin errors++; $display("FAIL valid_width got=%0d exp=%0d", vld_clks, HV * CD); end
  endtask

  task automatic test_frame_wrap();
    int target, vmin = 9999, vmax = -1, last_ls = -1;
    target = HT * VT * CD + 1;
    for (int k = 0; k < HT * VT * CD + 10 && e < target; k++) begin
      @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL frame_run e=%0d got=%h exp=%h", e, got, model(e));
      end
      if (!vsync && h_cnt == 10'd400) begin
        if (int'(v_cnt) < vmin) vmin = int'(v_cnt);
        if (int'(v_cnt) > vmax) vmax = int'(v_cnt);
      end
      if (line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (e - last_ls != HT * CD) begin errors++; $display("FAIL line_period got=%0d exp=%0d", e - last_ls, HT * CD); end
        end
        last_ls = e;
      end
    end
    checks++;
    if (e != target) begin errors++; $display("FAIL frame_timeout got=%0d exp=%0d", e, target); end
    checks++;
    if (got.h !== 10'd0 || got.v !== 10'd0 || got.line_start !== 1'b1 || got.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_wrap got=(%0d,%0d) ls=%b fs=%b exp=(0,0) ls=1 fs=1",
               got.h, got.v, got.line_start, got.frame_start);
    end
    checks++;
    if (vmin != VV + VF || vmax != VV + VF + VS - 1) begin
      errors++; $display("FAIL vsync_span got=%0d..%0d exp=%0d..%0d", vmin, vmax, VV + VF, VV + VF + VS - 1);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width got=%b exp=0", frame_start); end
  endtask

  task automatic test_mid_reset();
    int vr, off, target, hold, rise = -1;
    vr = $urandom_range(1, 3);
    off = $urandom_range(0, CD - 1);
    target = (HT * VT + vr * HT + 300) * CD + 1 + off;
    for (int k = 0; k < 20000 && e < target; k++) begin
      @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL mid_run e=%0d got=%h exp=%h", e, got, model(e));
      end
    end
    checks++;
    if (got.h !== 10'd300 || got.v !== 10'(vr)) begin
      errors++; $display("FAIL mid_pos got=(%0d,%0d) exp=(300,%0d)", got.h, got.v, vr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got !== model(0)) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, model(0)); end
    hold = $urandom_range(1, 3);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got !== model(0)) begin errors++; $display("FAIL reset_held got=%h exp=%h", got, model(0)); end
    rst = 1'b0;
    for (int i = 0; i < 3 * CD; i++) begin
      @(negedge clk);
      checks++;
      if (got !== model(e)) begin
        errors++;
        if (errors <= 20) $display("FAIL restart e=%0d got=%h exp=%h", e, got, model(e));
      end
      if (valid && rise < 0) rise = e;
    end
    checks++;
    if (rise != 1 + LAG * CD) begin errors++; $display("FAIL valid_rise got=%0d exp=%0d", rise, 1 + LAG * CD); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_divider();
    test_line_wrap();
    test_hsync_line();
    test_frame_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
